if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage feeding the decode stage and its opcode decoder. It owns the fetch PC and issues single-word reads to instruction memory, with at most one request outstanding. Returned words go into a 2-entry instruction buffer, which presents one instruction per cycle to decode. The stage honours decode freeze and redirects on a taken branch/jump from the execute stage, discarding stale fetches.

## Interface
- ADDR_W, 32, width of PC and memory address
- INSTR_W, 32, instruction width
- RESET_PC, 0, fetch address after reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  read request; memory accepts every cycle it is high
- imem_addr  out  ADDR_W  word-aligned read address, valid with imem_req
- imem_valid  in  1  response strobe; exactly one per accepted request, in order, ≥1 cycle after request
- imem_rdata  in  INSTR_W  response data, valid with imem_valid
- freeze  in  1  decode stall; head instruction is not consumed
- branch_taken  in  1  redirect request
- branch_addr  in  ADDR_W  redirect target, word-aligned
- if_valid  out  1  head of buffer holds an instruction
- if_pc  out  ADDR_W  address of head instruction
- if_instr  out  INSTR_W  head instruction; all-zero (NOP opcode 000000) when if_valid=0

## Operation
- State:
  - fetch_pc (ADDR_W)
  - busy (one request outstanding)
  - drop (outstanding response is stale)
  - 2-entry FIFO of {pc, instr}, count 0..2
- pop = if_valid & ~freeze & ~branch_taken.
- accept = imem_valid & ~drop & ~branch_taken. The returned word is pushed with pc equal to the address of its request.
- Free slot for issue: issue is allowed only when count − pop + accept + 0 < 2.
- imem_req = ~branch_taken & (~busy | imem_valid) & (count − pop + accept < 2).
- imem_addr = fetch_pc.
- On imem_req:
  - fetch_pc ← fetch_pc + 4, modulo 2^ADDR_W
  - busy ← 1
- On imem_valid without a new request: busy ← 0.
- On imem_valid with drop=1: data is discarded and drop ← 0.
- branch_taken has priority over every other event in its cycle:
  - FIFO is flushed (count ← 0) and fetch_pc ← branch_addr.
  - imem_req is held low.
  - A response arriving in the same cycle is discarded.
  - If busy and no response arrives this cycle, drop ← 1 and busy stays 1.
- Simultaneous push and pop: count is unchanged, FIFO order is preserved.
- branch_taken together with freeze: branch wins and the head is flushed.
- Bits [1:0] of fetch_pc and branch_addr are passed through unchecked.

## Timing
- Reset (rst low, asynchronous):
  - fetch_pc=RESET_PC, busy=0, drop=0, count=0
  - if_valid=0, if_pc=0, if_instr=0
  - imem_req=0 while rst is low
- Reset mid-operation: all in-flight state is lost. Any later imem_valid belonging to a pre-reset request is the memory's responsibility and must not occur.
- imem_req is combinational from state and inputs. Registered state updates on the clk rising edge.
- Latency:
  - A response sampled at edge N appears on if_valid/if_instr after edge N.
  - With 1-cycle memory, the first instruction is valid 2 cycles after rst deasserts.
- Throughput: one instruction/cycle sustained with 1-cycle memory. With L-cycle memory it is 1/L.
- Redirect: first request to branch_addr is issued in the cycle after branch_taken if no stale response is pending. Otherwise it is issued in the cycle the stale response arrives.
- Full buffer (count=2) with freeze held: imem_req stays low, and busy is 0 by construction.

## Test plan
- Reset, 1-cycle memory returning addr-as-data, freeze=0:
  - imem_addr sequence 0,4,8,…
  - if_pc/if_instr 0,4,8 on consecutive cycles from cycle 2
- freeze high for 5 cycles mid-stream:
  - head held constant
  - count reaches 2, imem_req low, no instruction lost or duplicated
  - resume is gap-free
- 3-cycle memory, branch_taken with branch_addr=0x40 while a request to 0x10 is outstanding:
  - response for 0x10 is discarded
  - next imem_addr=0x40, next if_pc=0x40
- branch_taken in the same cycle as imem_valid and freeze=1:
  - FIFO empties, response is dropped, if_valid=0 next cycle, if_instr=0
- rst pulsed low asynchronously between edges while count=2:
  - if_valid, if_pc and imem_req go to 0 immediately
  - fetch restarts at RESET_PC
- fetch_pc=0xFFFFFFFC: next imem_addr wraps to 0x00000000.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one memory read in flight,
// and buffers returned words in a 2-entry FIFO that presents one instruction per cycle to decode.
module if_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr
);

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  req_pc;
    logic               busy;
    logic               drop;
    logic [1:0]         count;
    logic [ADDR_W-1:0]  pc_q    [2];
    logic [INSTR_W-1:0] instr_q [2];

    logic [ADDR_W-1:0]  pc_n    [2];
    logic [INSTR_W-1:0] instr_n [2];
    logic               pop;
    logic               accept;
    logic [2:0]         base;
    logic [2:0]         occ;

    assign if_valid  = (count != 2'd0);
    assign pop       = if_valid & ~freeze & ~branch_taken;
    assign accept    = imem_valid & ~drop & ~branch_taken;
    assign base      = {1'b0, count} - {2'b00, pop};
    assign occ       = base + {2'b00, accept};

    // A new request is only issued when the buffer keeps a slot free for its response.
    assign imem_req  = rst & ~branch_taken & (~busy | imem_valid) & (occ < 3'd2);
    assign imem_addr = fetch_pc;

    assign if_pc     = if_valid ? pc_q[0]    : '0;
    assign if_instr  = if_valid ? instr_q[0] : '0;

    always_comb begin
        pc_n    = pc_q;
        instr_n = instr_q;
        if (pop) begin
            pc_n[0]    = pc_q[1];
            instr_n[0] = instr_q[1];
        end
        if (accept) begin
            if (base != 3'd0) begin
                pc_n[1]    = req_pc;
                instr_n[1] = imem_rdata;
            end else begin
                pc_n[0]    = req_pc;
                instr_n[0] = imem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc   <= RESET_PC;
            req_pc     <= '0;
            busy       <= 1'b0;
            drop       <= 1'b0;
            count      <= 2'd0;
            pc_q[0]    <= '0;
            pc_q[1]    <= '0;
            instr_q[0] <= '0;
            instr_q[1] <= '0;
        end else if (branch_taken) begin
            // Redirect wins: flush, retarget, and mark an in-flight read as stale.
            count    <= 2'd0;
            fetch_pc <= branch_addr;
            if (imem_valid) begin
                busy <= 1'b0;
                drop <= 1'b0;
            end else if (busy) begin
                drop <= 1'b1;
            end
        end else begin
            count   <= occ[1:0];
            pc_q    <= pc_n;
            instr_q <= instr_n;
            if (imem_req) begin
                fetch_pc <= fetch_pc + ADDR_W'(4);
                req_pc   <= fetch_pc;
                busy     <= 1'b1;
            end else if (imem_valid) begin
                busy <= 1'b0;
            end
            if (imem_valid && drop) begin
                drop <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a latency-configurable memory model, an instruction-stream
// reference model, a cycle-exact vector table and directed corner-case sequences.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    if_fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_rdata   (imem_rdata),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    typedef struct {
        logic        freeze;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    mreq_t       mem_q[$];
    int          lat = 1;
    int          cyc = 0;
    int          epoch = 0;
    int          resp_epoch = 0;
    int          buffered = 0;
    int          pops = 0;
    logic [31:0] salt = '0;
    logic [31:0] exp_pc = '0;
    logic [31:0] exp_req = '0;
    logic        freeze_v = 1'b0;
    logic        branch_v = 1'b0;
    logic [31:0] baddr_v = '0;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_instr;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ salt;
    endfunction

    // Compares one cycle of DUT behaviour against the expected instruction stream,
    // then advances the stream according to what the cycle consumed or redirected.
    task automatic model_cycle();
        logic acc, pp;
        check("if_valid", 32'(s_valid), 32'(buffered > 0));
        if (s_valid) begin
            check("if_pc", s_pc, exp_pc);
            check("if_instr", s_instr, data_of(exp_pc));
        end else begin
            check("if_instr_nop", s_instr, 32'h0);
        end
        if (branch_v) check("req_in_branch", 32'(s_req), 32'h0);
        if (s_req) begin
            check("imem_addr", s_addr, exp_req);
            exp_req = exp_req + 32'd4;
            mem_q.push_back('{addr: s_addr, due: cyc + lat, epoch: epoch});
            check("outstanding_le1", 32'(mem_q.size() <= 1), 32'h1);
        end
        acc = imem_valid && (resp_epoch == epoch) && !branch_v;
        pp  = s_valid && !freeze_v && !branch_v;
        if (branch_v) begin
            buffered = 0;
            epoch++;
            exp_pc  = baddr_v;
            exp_req = baddr_v;
        end else begin
            if (pp) begin
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            buffered = buffered + int'(acc) - int'(pp);
            check("buffer_le2", 32'(buffered <= 2), 32'h1);
        end
    endtask

    // Entered and left at posedge+1: drive inputs, sample mid-cycle, advance.
    task automatic tick();
        freeze       = freeze_v;
        branch_taken = branch_v;
        branch_addr  = baddr_v;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_valid = 1'b1;
            imem_rdata = data_of(mem_q[0].addr);
            resp_epoch = mem_q[0].epoch;
            void'(mem_q.pop_front());
        end else begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
        end
        @(negedge clk);
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = if_valid;
        s_pc    = if_pc;
        s_instr = if_instr;
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asserts reset between clock edges and checks the outputs clear at once.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        check("rst_if_valid", 32'(if_valid), 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_imem_req", 32'(imem_req), 32'h0);
        freeze_v = 1'b0;
        branch_v = 1'b0;
        baddr_v  = '0;
        freeze = 1'b0;
        branch_taken = 1'b0;
        imem_valid = 1'b0;
        mem_q.delete();
        buffered = 0;
        pops = 0;
        exp_pc = 32'h0;
        exp_req = 32'h0;
        epoch++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
    endtask

    initial begin
        int k;

        // Reset, 1-cycle addr-as-data memory, freeze held for cycles 5..9.
        tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h04};
        tbl[4]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
        tbl[5]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
        tbl[6]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
        tbl[7]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
        tbl[8]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
        tbl[9]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
        tbl[10] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
        tbl[11] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
        tbl[12] = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h14};
        tbl[13] = '{1'b0, 1'b1, 32'h20, 1'b1, 32'h18};

        lat = 1;
        salt = '0;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            freeze_v = tbl[i].freeze;
            tick();
            check("tbl_req", 32'(s_req), 32'(tbl[i].req));
            if (tbl[i].req) check("tbl_addr", s_addr, tbl[i].addr);
            check("tbl_valid", 32'(s_valid), 32'(tbl[i].valid));
            if (tbl[i].valid) check("tbl_pc", s_pc, tbl[i].pc);
            check("tbl_instr", s_instr, tbl[i].valid ? tbl[i].pc : 32'h0);
        end

        // 3-cycle memory: redirect to 0x40 while the read of 0x10 is in flight.
        lat = 3;
        salt = $urandom;
        do_reset();
        k = 0;
        while (!(s_req && s_addr == 32'h10) && k < 100) begin
            tick();
            k++;
        end
        check("seqa_saw_0x10", 32'(s_req && s_addr == 32'h10), 32'h1);
        tick();
        branch_v = 1'b1;
        baddr_v  = 32'h40;
        tick();
        branch_v = 1'b0;
        k = 0;
        do begin
            tick();
            k++;
        end while (!s_req && k < 20);
        check("seqa_redirect_addr", s_addr, 32'h40);
        k = 0;
        do begin
            tick();
            k++;
        end while (!s_valid && k < 20);
        check("seqa_first_pc", s_pc, 32'h40);

        // Branch together with freeze while a response arrives.
        lat = 1;
        do_reset();
        repeat (6) tick();
        freeze_v = 1'b1;
        branch_v = 1'b1;
        baddr_v  = 32'h200;
        tick();
        check("seqb_req_low", 32'(s_req), 32'h0);
        freeze_v = 1'b0;
        branch_v = 1'b0;
        tick();
        check("seqb_valid_low", 32'(s_valid), 32'h0);
        check("seqb_instr_zero", s_instr, 32'h0);
        check("seqb_req", 32'(s_req), 32'h1);
        check("seqb_addr", s_addr, 32'h200);
        repeat (4) tick();

        // Asynchronous reset while the buffer is full under freeze.
        do_reset();
        repeat (5) tick();
        freeze_v = 1'b1;
        repeat (4) tick();
        check("seqc_full_valid", 32'(s_valid), 32'h1);
        check("seqc_full_req", 32'(s_req), 32'h0);
        do_reset();
        tick();
        check("seqc_restart_req", 32'(s_req), 32'h1);
        check("seqc_restart_addr", s_addr, 32'h0);
        repeat (4) tick();

        // Fetch address wrap-around.
        do_reset();
        repeat (3) tick();
        branch_v = 1'b1;
        baddr_v  = 32'hFFFF_FFFC;
        tick();
        branch_v = 1'b0;
        tick();
        check("seqd_addr_top", s_addr, 32'hFFFF_FFFC);
        tick();
        check("seqd_addr_wrap", s_addr, 32'h0000_0000);
        repeat (4) tick();

        // Randomised traffic against the stream model.
        for (int r = 0; r < 4; r++) begin
            lat = int'($urandom_range(1, 4));
            salt = $urandom;
            do_reset();
            for (int c = 0; c < 500; c++) begin
                freeze_v = ($urandom_range(0, 9) < 3);
                branch_v = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 3) == 0)
                    baddr_v = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
                else
                    baddr_v = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} & 32'hFFFF_FFFC;
                tick();
            end
            check("rand_progress", 32'(pops > 0), 32'h1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
